// File: rtl/dbg_event_trace_buffer.sv
// Event-trace capture: timestamps rising edges of the stage handshake strobes and
// queues them in a first-word-fall-through FIFO drained over a valid/ready port.
module dbg_event_trace_buffer #(
  parameter int DEPTH = 64,
  parameter int TS_W  = 24,
  parameter int EVT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm_i,
  input  logic                     stop_i,
  input  logic                     clear_i,
  input  logic [EVT_W-1:0]         evt_i,
  input  logic                     rd_rdy_i,
  output logic                     rd_vld_o,
  output logic [31:0]              rd_data_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic [1:0]               state_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [EVT_W-1:0]  evt_prev_reg;
  logic [EVT_W-1:0]  rise;
  logic [TS_W-1:0]   ts_reg;
  logic [31:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]     cnt_reg;
  logic              overflow_reg;
  logic [31:0]       last_reg;
  logic              empty, full, pop, push_try, push, drop;

  assign rise     = evt_i & ~evt_prev_reg;
  assign empty    = (cnt_reg == '0);
  assign full     = (cnt_reg == CW'(DEPTH));
  assign pop      = !empty && rd_rdy_i;
  assign push_try = (state_reg == CAPTURE) && !clear_i && !stop_i && (rise != '0);
  // A full FIFO only drops when the same cycle does not free a slot.
  assign drop     = push_try && full && !pop;
  assign push     = push_try && !drop;

  always_comb begin
    state_next = state_reg;
    if (clear_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: if (arm_i) state_next = CAPTURE;
        CAPTURE:    if (stop_i || drop) state_next = DONE;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {ts_reg, rise};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_prev_reg <= '0;
      ts_reg       <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      cnt_reg      <= '0;
      overflow_reg <= 1'b0;
      last_reg     <= '0;
    end else begin
      evt_prev_reg <= evt_i;
      if (clear_i) begin
        ts_reg       <= '0;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        cnt_reg      <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
          last_reg   <= mem[rd_ptr_reg];
        end
        cnt_reg <= cnt_reg + CW'(push) - CW'(pop);
        if (drop) overflow_reg <= 1'b1;
        // Timestamp restarts on arm, counts while capturing, saturates at all-ones.
        if (state_reg != CAPTURE) begin
          if (arm_i) ts_reg <= '0;
        end else if (ts_reg != '1) begin
          ts_reg <= ts_reg + 1'b1;
        end
      end
    end
  end

  assign rd_vld_o   = !empty;
  assign rd_data_o  = empty ? last_reg : mem[rd_ptr_reg];
  assign cnt_o      = cnt_reg;
  assign state_o    = state_reg;
  assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_dbg_event_trace_buffer.sv
// Directed bench for dbg_event_trace_buffer: a queue-based reference model checked every
// cycle on two instances (DEPTH=4 with 24-bit and 4-bit timestamps), plus literal checks.
module tb_dbg_event_trace_buffer;

  logic        clk = 1'b0;
  logic        rst, arm, stop, clear, rd_rdy;
  logic [7:0]  evt;

  logic        vld0, vld1, ovf0, ovf1;
  logic [31:0] data0, data1;
  logic [2:0]  cnt0, cnt1;
  logic [1:0]  st0, st1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbg_event_trace_buffer #(.DEPTH(4), .TS_W(24), .EVT_W(8)) u_dut (
    .clk(clk), .rst(rst), .arm_i(arm), .stop_i(stop), .clear_i(clear),
    .evt_i(evt), .rd_rdy_i(rd_rdy), .rd_vld_o(vld0), .rd_data_o(data0),
    .cnt_o(cnt0), .state_o(st0), .overflow_o(ovf0)
  );

  dbg_event_trace_buffer #(.DEPTH(4), .TS_W(4), .EVT_W(28)) u_sat (
    .clk(clk), .rst(rst), .arm_i(arm), .stop_i(stop), .clear_i(clear),
    .evt_i({20'd0, evt}), .rd_rdy_i(rd_rdy), .rd_vld_o(vld1), .rd_data_o(data1),
    .cnt_o(cnt1), .state_o(st1), .overflow_o(ovf1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: states 0=IDLE 1=CAPTURE 2=DONE, FIFO as a queue.
  localparam int MDEPTH = 4;
  int          m_state [2];
  logic [31:0] m_ts    [2];
  logic [31:0] m_prev  [2];
  bit          m_ovf   [2];
  logic [31:0] m_q     [2][$];
  logic [31:0] ts_max  [2] = '{32'h00FF_FFFF, 32'h0000_000F};
  int          ts_sh   [2] = '{8, 28};
  bit          mdl_on = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [31:0] rise;
      int          sz;
      bit          do_pop;
      rise   = {24'd0, evt} & ~m_prev[k];
      sz     = m_q[k].size();
      do_pop = (sz > 0) && rd_rdy;
      if (rst) begin
        mdl_on     = 1'b1;
        m_state[k] = 0;
        m_ts[k]    = 0;
        m_prev[k]  = 0;
        m_ovf[k]   = 0;
        m_q[k].delete();
      end else begin
        if (clear) begin
          m_q[k].delete();
          m_ovf[k]   = 0;
          m_ts[k]    = 0;
          m_state[k] = 0;
        end else begin
          if (do_pop) void'(m_q[k].pop_front());
          if (m_state[k] == 1) begin
            if (stop) m_state[k] = 2;
            else if (rise != 0) begin
              if (sz == MDEPTH && !do_pop) begin
                m_ovf[k]   = 1;
                m_state[k] = 2;
              end else begin
                m_q[k].push_back((m_ts[k] << ts_sh[k]) | rise);
              end
            end
            if (m_ts[k] < ts_max[k]) m_ts[k] = m_ts[k] + 1;
          end else if (arm) begin
            m_state[k] = 1;
            m_ts[k]    = 0;
          end
        end
        m_prev[k] = {24'd0, evt};
      end
    end
  end

  task automatic cmp_inst(input int k, input logic [1:0] st, input logic [2:0] cnt,
                          input logic vld, input logic [31:0] data, input logic ovf);
    string p;
    p = (k == 0) ? "dut" : "sat";
    chk({p, ".state"}, 32'(st), 32'(m_state[k]));
    chk({p, ".cnt"}, 32'(cnt), 32'(m_q[k].size()));
    chk({p, ".vld"}, 32'(vld), 32'(m_q[k].size() > 0));
    chk({p, ".ovf"}, 32'(ovf), 32'(m_ovf[k]));
    if (m_q[k].size() > 0) chk({p, ".data"}, data, m_q[k][0]);
  endtask

  always @(posedge clk) begin
    #1;
    if (mdl_on) begin
      cmp_inst(0, st0, cnt0, vld0, data0, ovf0);
      cmp_inst(1, st1, cnt1, vld1, data1, ovf1);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] prev_ts;

  initial begin
    rst = 1'b1; arm = 0; stop = 0; clear = 0; rd_rdy = 0; evt = 8'h00;
    tick(2);
    chk("reset.cnt", 32'(cnt0), 32'd0);
    chk("reset.state", 32'(st0), 32'd0);
    chk("reset.vld", 32'(vld0), 32'd0);
    chk("reset.data", data0, 32'd0);
    chk("reset.ovf", 32'(ovf0), 32'd0);
    rst = 1'b0;
    tick();

    // First entry: arm at cycle 0, bit7 rises at cycle 5 with ts=4.
    arm = 1; tick(); arm = 0;
    tick(4);
    evt = 8'h80; tick();
    $display("txn first_event data=0x%08h cnt=%0d", data0, cnt0);
    chk("first.vld", 32'(vld0), 32'd1);
    chk("first.data", data0, 32'h0000_0480);
    chk("first.cnt", 32'(cnt0), 32'd1);
    chk("first.sat_data", data1, 32'h4000_0080);
    evt = 8'h00;
    rd_rdy = 1; tick(); rd_rdy = 0;
    chk("first.drained", 32'(cnt0), 32'd0);

    // Strobes high before arm do not record.
    clear = 1; tick(); clear = 0;
    evt = 8'h81; tick(2);
    arm = 1; tick(); arm = 0;
    tick(2);
    chk("prearm.none", 32'(cnt0), 32'd0);
    evt = 8'h00; tick(2);
    evt = 8'h03; tick();
    $display("txn prearm data=0x%08h cnt=%0d", data0, cnt0);
    chk("prearm.rise", data0 & 32'hFF, 32'h03);
    chk("prearm.cnt", 32'(cnt0), 32'd1);
    evt = 8'h00;
    rd_rdy = 1; tick(); rd_rdy = 0;

    // Overflow: five rises into four slots.
    clear = 1; tick(); clear = 0;
    arm = 1; tick(); arm = 0;
    for (int i = 0; i < 5; i++) begin
      evt = 8'(1 << i); tick();
      evt = 8'h00; tick();
    end
    $display("txn overflow cnt=%0d ovf=%0d state=%0d", cnt0, ovf0, st0);
    chk("ovf.cnt", 32'(cnt0), 32'd4);
    chk("ovf.flag", 32'(ovf0), 32'd1);
    chk("ovf.state", 32'(st0), 32'd2);
    prev_ts = 0;
    rd_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      $display("txn drain idx=%0d data=0x%08h", i, data0);
      chk("drain.vld", 32'(vld0), 32'd1);
      chk("drain.rise", data0 & 32'hFF, 32'(1 << i));
      if (i > 0) chk("drain.ts_incr", 32'(data0[31:8] > prev_ts[23:0]), 32'd1);
      prev_ts = {8'd0, data0[31:8]};
      tick();
    end
    rd_rdy = 0;
    chk("drain.empty", 32'(vld0), 32'd0);

    // Full with a coincident pop: the fifth event is accepted.
    clear = 1; tick(); clear = 0;
    arm = 1; tick(); arm = 0;
    for (int i = 0; i < 4; i++) begin
      evt = 8'(1 << i); tick();
      evt = 8'h00; tick();
    end
    evt = 8'h10; rd_rdy = 1; tick();
    evt = 8'h00; rd_rdy = 0;
    $display("txn full_pop cnt=%0d ovf=%0d state=%0d", cnt0, ovf0, st0);
    chk("fullpop.cnt", 32'(cnt0), 32'd4);
    chk("fullpop.ovf", 32'(ovf0), 32'd0);
    chk("fullpop.state", 32'(st0), 32'd1);

    // Mid-capture clear with three entries; the same-cycle arm is ignored.
    rd_rdy = 1; tick(); rd_rdy = 0;
    chk("clear.pre_cnt", 32'(cnt0), 32'd3);
    clear = 1; arm = 1; tick(); clear = 0; arm = 0;
    $display("txn clear cnt=%0d vld=%0d state=%0d", cnt0, vld0, st0);
    chk("clear.cnt", 32'(cnt0), 32'd0);
    chk("clear.vld", 32'(vld0), 32'd0);
    chk("clear.state", 32'(st0), 32'd0);
    chk("clear.ovf", 32'(ovf0), 32'd0);

    // Timestamp saturation, stop, re-arm with FIFO retained.
    arm = 1; tick(); arm = 0;
    tick(20);
    evt = 8'h01; tick();
    $display("txn sat data=0x%08h wide=0x%08h", data1, data0);
    chk("sat.data", data1, 32'hF000_0001);
    chk("sat.wide", data0, 32'h0000_1401);
    stop = 1; tick(); stop = 0;
    chk("sat.done", 32'(st1), 32'd2);
    evt = 8'h00; tick();
    evt = 8'h02; tick();
    evt = 8'h00; tick();
    chk("sat.done_nopush", 32'(cnt1), 32'd1);
    arm = 1; tick(); arm = 0;
    evt = 8'h04; tick();
    evt = 8'h00;
    chk("rearm.cnt", 32'(cnt1), 32'd2);
    chk("rearm.head", data1, 32'hF000_0001);
    rd_rdy = 1; tick();
    $display("txn rearm data=0x%08h", data1);
    chk("rearm.ts0", data1, 32'h0000_0004);
    tick(); rd_rdy = 0;
    chk("rearm.empty", 32'(cnt1), 32'd0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
